// File: rtl/mem_byte_access_unit.sv
// MEM-stage load/store unit: lane extract + sign/zero extend on loads, read-modify-write for SB/SH.
// Latency: Done 2 cycles after Start for loads/SW, 3 for SB/SH (same-cycle MemAck); +1 per ack wait cycle.
// Backpressure: Busy stalls the pipeline in READ/WRITE; MemRd/MemWr held until MemAck or TIMEOUT abort.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned halfword/word accesses without touching memory).
module mem_byte_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RdData,
  output logic        Err,
  output logic        Misalign,
  output logic [31:0] MemAddr,
  output logic        MemRd,
  output logic        MemWr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemAck
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t          state, state_nxt, start_state;
  logic [2:0]      op;
  logic [1:0]      lane;
  logic [31:0]     wdata;
  logic [CW-1:0]   wait_cnt;
  logic            accept, timeout, misal_start, op_is_load, op_is_sub;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [31:0]     load_val, merge_val;

  assign Busy  = (state == S_READ) || (state == S_WRITE);
  assign Done  = (state == S_DONE);
  assign MemRd = (state == S_READ);
  assign MemWr = (state == S_WRITE);

  // Start is only honoured when no access is in flight; DONE allows back-to-back issue.
  assign accept     = Start && ((state == S_IDLE) || (state == S_DONE));
  assign timeout    = Busy && !MemAck && (wait_cnt == CW'(TIMEOUT - 1));
  assign op_is_load = (op <= OP_LBU);
  assign op_is_sub  = (op == OP_SH) || (op == OP_SB);

`ifdef MISALIGN_TRAP_EN
  // Detect accesses whose size does not match the low address bits.
  always_comb begin
    misal_start = 1'b0;
    case (Op)
      OP_LH, OP_LHU, OP_SH: misal_start = Addr[0];
      OP_LW, OP_SW:         misal_start = |Addr[1:0];
      default:              misal_start = 1'b0;
    endcase
  end
`else
  assign misal_start = 1'b0;
`endif

  // Choose the first state of a newly accepted access.
  always_comb begin
    start_state = S_READ;
    if (misal_start)
      start_state = S_DONE;
    else if (Op == OP_SW)
      start_state = S_WRITE;
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = start_state;
      S_READ: begin
        if (MemAck)       state_nxt = op_is_sub ? S_WRITE : S_DONE;
        else if (timeout) state_nxt = S_DONE;
      end
      S_WRITE: if (MemAck || timeout) state_nxt = S_DONE;
      S_DONE:  state_nxt = accept ? start_state : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Per-phase ack wait counter; restarts on every state change.
  always_ff @(posedge Clk) begin
    if (Reset)                  wait_cnt <= '0;
    else if (state_nxt != state) wait_cnt <= '0;
    else if (Busy && !MemAck)   wait_cnt <= wait_cnt + CW'(1);
  end

  // Lane extraction, load extension and store merge from the returned word.
  always_comb begin
    byte_lane = MemRData[{lane, 3'b000} +: 8];
    half_lane = lane[1] ? MemRData[31:16] : MemRData[15:0];
    load_val  = MemRData;
    merge_val = MemRData;
    case (op)
      OP_LH:   load_val = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  load_val = {16'h0000, half_lane};
      OP_LB:   load_val = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  load_val = {24'h000000, byte_lane};
      default: load_val = MemRData;
    endcase
    if (op == OP_SB)
      merge_val[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (op == OP_SH)
      merge_val[{lane[1], 4'b0000} +: 16] = wdata[15:0];
  end

  // Request capture, result/status registers and write-word staging.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op       <= OP_LW;
      lane     <= 2'b00;
      wdata    <= '0;
      MemAddr  <= '0;
      MemWData <= '0;
      RdData   <= '0;
      Err      <= 1'b0;
      Misalign <= 1'b0;
    end else begin
      if (accept) begin
        op       <= Op;
        lane     <= Addr[1:0];
        wdata    <= WrData;
        MemAddr  <= {Addr[31:2], 2'b00};
        MemWData <= WrData;
        Err      <= 1'b0;
        Misalign <= misal_start;
      end
      if (MemRd && MemAck) begin
        if (op_is_load) RdData   <= load_val;
        else            MemWData <= merge_val;
      end
      if (timeout) Err <= 1'b1;
    end
  end

endmodule
